// File: rtl/video_timing_gen.sv
// Video timing generator: free-running pixel/line counters with registered
// sync, data-enable and frame/line marker outputs aligned to the coordinates.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CORDW    = 16
) (
  input  logic             video_clk_pix,
  input  logic             video_rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [1:0]       cd,
  output logic             frame,
  output logic             line
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT_C  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT_C  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_STA_C = CORDW'(HS_START);
  localparam logic [CORDW-1:0] HS_END_C = CORDW'(HS_END);
  localparam logic [CORDW-1:0] VS_STA_C = CORDW'(VS_START);
  localparam logic [CORDW-1:0] VS_END_C = CORDW'(VS_END);

  // The coordinate outputs must be able to represent the last pixel and line.
  if ((H_TOTAL - 1) >= (2 ** CORDW) || (V_TOTAL - 1) >= (2 ** CORDW)) begin : g_cordw_check
    $error("video_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CORDW-1:0] sx_next;
  logic [CORDW-1:0] sy_next;
  logic             de_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             frame_next;
  logic             line_next;

  // Next raster position plus every flag derived from it, so the registered
  // flags line up with the registered coordinates in the same cycle.
  always_comb begin
    sx_next = sx + CORDW'(1);
    sy_next = sy;
    if (sx == H_LAST) begin
      sx_next = '0;
      if (sy == V_LAST) begin
        sy_next = '0;
      end else begin
        sy_next = sy + CORDW'(1);
      end
    end

    de_next    = (sx_next < H_ACT_C) && (sy_next < V_ACT_C);
    hsync_next = ((sx_next >= HS_STA_C) && (sx_next < HS_END_C)) ? H_POL : ~H_POL;
    vsync_next = ((sy_next >= VS_STA_C) && (sy_next < VS_END_C)) ? V_POL : ~V_POL;
    line_next  = (sx_next == '0);
    frame_next = (sx_next == '0) && (sy_next == '0);
  end

  // Output registers; reset parks the raster on its last pixel so the first
  // released edge lands on (0,0) with the frame marker.
  always_ff @(posedge video_clk_pix) begin
    if (video_rst_pix) begin
      sx    <= H_LAST;
      sy    <= V_LAST;
      de    <= 1'b0;
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      cd    <= {~V_POL, ~H_POL};
      frame <= 1'b0;
      line  <= 1'b0;
    end else begin
      sx    <= sx_next;
      sy    <= sy_next;
      de    <= de_next;
      hsync <= hsync_next;
      vsync <= vsync_next;
      cd    <= {vsync_next, hsync_next};
      frame <= frame_next;
      line  <= line_next;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two small-timing generators (both sync polarities) are
// driven by a shared reset with random and directed pulses and compared each
// cycle against a raster model indexed by linear pixel position in the frame.
module tb_video_timing_gen;

  // Configuration A: active-low syncs
  localparam int A_HA = 16, A_HF = 4, A_HS = 6, A_HB = 5;
  localparam int A_VA = 10, A_VF = 2, A_VS = 3, A_VB = 4;
  localparam int A_CW = 8;
  // Configuration B: active-high syncs, narrow coordinates
  localparam int B_HA = 20, B_HF = 3, B_HS = 5, B_HB = 7;
  localparam int B_VA = 8,  B_VF = 1, B_VS = 2, B_VB = 3;
  localparam int B_CW = 6;

  typedef struct {
    int       sx;
    int       sy;
    bit       de;
    bit       hs;
    bit       vs;
    bit       fr;
    bit       ln;
    bit [1:0] cd;
  } exp_t;

  logic video_clk_pix = 1'b0;
  logic video_rst_pix = 1'b1;

  logic [A_CW-1:0] sx_a, sy_a;
  logic            de_a, hs_a, vs_a, fr_a, ln_a;
  logic [1:0]      cd_a;
  logic [B_CW-1:0] sx_b, sy_b;
  logic            de_b, hs_b, vs_b, fr_b, ln_b;
  logic [1:0]      cd_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 video_clk_pix = ~video_clk_pix;

  video_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(1'b0), .V_POL(1'b0), .CORDW(A_CW)
  ) dut_a (
    .video_clk_pix(video_clk_pix), .video_rst_pix(video_rst_pix),
    .sx(sx_a), .sy(sy_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .cd(cd_a), .frame(fr_a), .line(ln_a)
  );

  video_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(1'b1), .V_POL(1'b1), .CORDW(B_CW)
  ) dut_b (
    .video_clk_pix(video_clk_pix), .video_rst_pix(video_rst_pix),
    .sx(sx_b), .sy(sy_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .cd(cd_b), .frame(fr_b), .line(ln_b)
  );

  // Expected outputs for a given linear position in the frame; reset parks
  // the model on the last position, which yields the held reset values.
  function automatic exp_t model(int pos, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, bit hp, bit vp);
    exp_t e;
    int   ht;
    ht    = ha + hf + hs + hb;
    e.sx  = pos % ht;
    e.sy  = pos / ht;
    e.de  = (e.sx < ha) && (e.sy < va);
    e.hs  = (e.sx >= ha + hf && e.sx < ha + hf + hs) ? hp : ~hp;
    e.vs  = (e.sy >= va + vf && e.sy < va + vf + vs) ? vp : ~vp;
    e.ln  = (e.sx == 0);
    e.fr  = (e.sx == 0) && (e.sy == 0);
    e.cd  = {e.vs, e.hs};
    return e;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag, exp_t e, logic [31:0] sx, logic [31:0] sy,
                             logic de, logic hs, logic vs, logic fr, logic ln,
                             logic [1:0] cd);
    cmp({tag, ".sx"},    sx, e.sx);
    cmp({tag, ".sy"},    sy, e.sy);
    cmp({tag, ".de"},    {31'b0, de}, {31'b0, e.de});
    cmp({tag, ".hsync"}, {31'b0, hs}, {31'b0, e.hs});
    cmp({tag, ".vsync"}, {31'b0, vs}, {31'b0, e.vs});
    cmp({tag, ".frame"}, {31'b0, fr}, {31'b0, e.fr});
    cmp({tag, ".line"},  {31'b0, ln}, {31'b0, e.ln});
    cmp({tag, ".cd"},    {30'b0, cd}, {30'b0, e.cd});
  endtask

  // Drives reset for the coming edge and pushes the expected result of that edge.
  task automatic applyStimulus(input bit r, inout int pos_a, inout int pos_b);
    int ta, tb;
    ta = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);
    tb = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);
    @(negedge video_clk_pix);
    video_rst_pix = r;
    pos_a = r ? ta - 1 : (pos_a + 1) % ta;
    pos_b = r ? tb - 1 : (pos_b + 1) % tb;
    qa.push_back(model(pos_a, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0));
    qb.push_back(model(pos_b, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1));
  endtask

  // Monitor for configuration A
  initial begin
    exp_t e;
    forever begin
      @(posedge video_clk_pix);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        checkOutput("A", e, sx_a, sy_a, de_a, hs_a, vs_a, fr_a, ln_a, cd_a);
      end
    end
  end

  // Monitor for configuration B
  initial begin
    exp_t e;
    forever begin
      @(posedge video_clk_pix);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        checkOutput("B", e, sx_b, sy_b, de_b, hs_b, vs_b, fr_b, ln_b, cd_b);
      end
    end
  end

  // Stimulus: initial reset, long free run, a directed 3-cycle mid-frame
  // reset, and occasional random reset pulses.
  initial begin
    int pos_a = 0;
    int pos_b = 0;
    int hold  = 0;
    bit r;
    $display("[TB] start");
    for (int c = 0; c < 2200; c++) begin
      if (c < 3) begin
        r = 1'b1;
      end else if (c >= 1300 && c < 1303) begin
        r = 1'b1;
      end else if (hold > 0) begin
        r = 1'b1;
        hold--;
      end else if (c > 1500 && $urandom_range(0, 249) == 0) begin
        r = 1'b1;
        hold = $urandom_range(0, 3);
      end else begin
        r = 1'b0;
      end
      applyStimulus(r, pos_a, pos_b);
    end
    applyStimulus(1'b0, pos_a, pos_b);
    repeat (3) @(posedge video_clk_pix);
    #2;
    cmp("A.drain", qa.size(), 0);
    cmp("B.drain", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have parameter H_POL, default 0, meaning hsync asserted level (0 = active-low).
REQ-010 The block SHALL have parameter V_POL, default 0, meaning vsync asserted level (0 = active-low).
REQ-011 The block SHALL have parameter CORDW, default 16, meaning width of the coordinate outputs.
REQ-012 Port video_clk_pix, input, width 1: pixel clock; the only clock in the block.
REQ-013 Port video_rst_pix, input, width 1: reset, synchronous and active-high.
REQ-014 Port sx, output, width CORDW: horizontal position, 0..H_TOTAL-1.
REQ-015 Port sy, output, width CORDW: vertical position, 0..V_TOTAL-1.
REQ-016 Port de, output, width 1: data enable, for the encoder VDE input.
REQ-017 Port hsync, output, width 1: horizontal sync at H_POL level.
REQ-018 Port vsync, output, width 1: vertical sync at V_POL level.
REQ-019 Port cd, output, width 2: {vsync, hsync}, for the blue-channel encoder CD input.
REQ-020 Port frame, output, width 1: one-cycle pulse at (0,0).
REQ-021 Port line, output, width 1: one-cycle pulse at sx==0 of every line, blanking lines included.

Function
REQ-022 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP; both are elaboration-time constants.
REQ-023 Line order SHALL be active, front porch, sync, back porch; frame order SHALL be the same.
REQ-024 Out of reset, sx SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-025 On wrap of sx, sy SHALL increment by 1; sy SHALL wrap from V_TOTAL-1 to 0 on the same cycle sx wraps.
REQ-026 All outputs SHALL be registered (flop outputs only), with de/hsync/vsync/cd/frame/line aligned to sx/sy in the same cycle; flags are therefore computed from next-state counter values.
REQ-027 de SHALL be 1 iff sx<H_ACTIVE and sy<V_ACTIVE.
REQ-028 hsync SHALL be at H_POL iff H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC; otherwise at ~H_POL.
REQ-029 vsync SHALL be at V_POL iff V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC, for the whole of each such line; otherwise at ~V_POL.
REQ-030 cd SHALL equal {vsync, hsync} every cycle, including during reset.
REQ-031 frame SHALL be 1 iff sx==0 and sy==0; line SHALL be 1 iff sx==0.
REQ-032 Counter arithmetic SHALL be unsigned CORDW-bit; CORDW SHALL be wide enough to hold H_TOTAL-1 and V_TOTAL-1, checked at elaboration.

Reset
REQ-033 While video_rst_pix=1 the block SHALL hold sx=H_TOTAL-1, sy=V_TOTAL-1, de=0, frame=0, line=0, hsync=~H_POL, vsync=~V_POL.
REQ-034 The first clock edge with video_rst_pix=0 SHALL produce sx=0, sy=0, de=1, frame=1, line=1.
REQ-035 Reset asserted mid-frame SHALL take effect on the next edge with no partial-line completion.

Verification
REQ-036 Defaults, release reset -> first cycle (0,0) with de=1, frame=1; frame repeats every 420000 cycles.
REQ-037 Defaults, one line -> de=1 for sx 0..639; hsync=0 exactly for sx 656..751 (96 cycles); line pulse every 800 cycles.
REQ-038 Defaults, one frame -> vsync=0 exactly on lines 490..491 (1600 cycles); de=0 on lines 480..524; 307200 de cycles per frame.
REQ-039 Wrap check -> (799,524) is followed by (0,0); (799,n) is followed by (0,n+1).
REQ-040 Reset asserted at (300,200) for 3 cycles -> held outputs per REQ-033; after release, first output is (0,0) with frame=1.
REQ-041 H_POL=1, V_POL=1, 1280x720 timing (110/40/220, 5/5/20) -> hsync=1 for sx 1390..1429; vsync=1 on lines 725..729; H_TOTAL=1650, V_TOTAL=750.
